cmp_flag_debouncer: RTL
=======================

Name: cmp_flag_debouncer

Overview:
- Downstream stage of the 4-bit magnitude comparator. Consumes its one-hot a_Eq_b / a_grt_b / a_less_b result flags, one sample per valid cycle.
- Produces a debounced, hysteretic "above" level with rise/fall pulses.
- Also maintains saturating counters of equal samples and threshold crossings, plus a sticky error flag for illegal (non-one-hot) flag combinations.

Parameters:
- DEBOUNCE_LEN, 4, consecutive qualifying samples required to change state; legal range 1..255.
- CNT_W, 8, width of eq_count and cross_count.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- flag_valid  input  1  comparator flags valid this cycle; sample accepted when high.
- a_eq_b  input  1  comparator equal flag.
- a_grt_b  input  1  comparator greater flag.
- a_less_b  input  1  comparator less flag.
- clear  input  1  synchronous clear of counters and flag_err; FSM unaffected.
- above  output  1  debounced level: 1 in HIGH or FALLING state.
- rise_pulse  output  1  one-cycle pulse on LOW/RISING->HIGH transition.
- fall_pulse  output  1  one-cycle pulse on HIGH/FALLING->LOW transition.
- flag_err  output  1  sticky; set by a valid non-one-hot flag sample.
- eq_count  output  CNT_W  saturating count of accepted equal samples.
- cross_count  output  CNT_W  saturating count of rise plus fall transitions.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State=LOW, run counter=0.
  - above=0, rise_pulse=0, fall_pulse=0, flag_err=0, eq_count=0, cross_count=0.
  - Reset overrides clear and any sample; reset mid-debounce discards the partial run.
- Accepted sample: flag_valid=1 and exactly one of {eq, grt, less} high.
  - flag_valid=1 with zero or more than one flag high sets flag_err=1. That sample is otherwise ignored: no state, run or count change.
  - flag_valid=0 cycles are ignored and do not break a run.
- Run counter width is clog2(DEBOUNCE_LEN+1) and never exceeds DEBOUNCE_LEN.
- FSM states and transitions (accepted samples only):
  - LOW: grt -> run=1; if run reaches DEBOUNCE_LEN go to HIGH, else RISING. eq/less -> stay LOW, run=0.
  - RISING: grt -> run+1; at DEBOUNCE_LEN go to HIGH, run=0. eq/less -> LOW, run=0.
  - HIGH: less -> run=1; if run reaches DEBOUNCE_LEN go to LOW, else FALLING. eq/grt -> stay HIGH, run=0.
  - FALLING: less -> run+1; at DEBOUNCE_LEN go to LOW, run=0. eq/grt -> HIGH, run=0.
  - Equal samples form the hysteresis band: they never advance a run and always cancel a pending one.
- Latency: all outputs registered. above and the pulses reflect the transition in the cycle after the edge at which the DEBOUNCE_LEN-th qualifying sample is accepted. Pulses are high for exactly one cycle.
- DEBOUNCE_LEN=1: LOW->HIGH directly on one grt sample; RISING/FALLING are never entered.
- Counters:
  - eq_count increments on each accepted eq sample.
  - cross_count increments on each rise or fall transition.
  - Both saturate at 2^CNT_W-1; no wrap-around.
- clear=1:
  - eq_count, cross_count and flag_err become 0 at that edge. Clear wins over a same-cycle increment or error set.
  - FSM, run counter and pulses still process the same-cycle sample normally.
- Unreachable state encodings recover to LOW with run=0 on the next edge.

Test Plan:
- Reset then DEBOUNCE_LEN=4, four consecutive valid grt samples -> above=1 and rise_pulse=1 for one cycle, in the cycle after the 4th sample; cross_count=1.
- Sequence grt,grt,grt,eq,grt,grt,grt,grt -> no rise after the first three (eq cancels run); rise after the 8th sample; eq_count=1.
- In HIGH: less,less,idle(flag_valid=0),less,less -> fall_pulse after the 4th less; above=0; cross_count=2. The idle cycle does not break the run.
- flag_valid=1 with grt=1 and less=1 -> flag_err=1 and stays 1; state, run and counts unchanged. Then clear=1 -> flag_err=0 and counters=0, state retained.
- CNT_W=2, five accepted eq samples -> eq_count sequence 1,2,3,3,3 (saturates). Clear coincident with an eq sample -> eq_count=0.
- Three grt samples, then rst_n=0 for one cycle, then one grt sample -> above stays 0, no rise_pulse; the partial run is discarded.

Source files
------------

// File: rtl/cmp_flag_debouncer.sv
// Debounces the comparator's one-hot flags into a hysteretic "above" level with
// rise/fall pulses, saturating eq/crossing counters and a sticky illegal-flag error.
module cmp_flag_debouncer #(
  parameter int unsigned DEBOUNCE_LEN = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_valid,
  input  logic             a_eq_b,
  input  logic             a_grt_b,
  input  logic             a_less_b,
  input  logic             clear,
  output logic             above,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             flag_err,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] cross_count
);

  localparam int unsigned      RUN_W    = $clog2(DEBOUNCE_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_ZERO = {RUN_W{1'b0}};
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_RISING  = 2'd1,
    ST_HIGH    = 2'd2,
    ST_FALLING = 2'd3
  } state_t;

  function automatic logic is_one_hot3(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
  endfunction

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             above_q, above_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_W-1:0] cross_q, cross_d;

  logic             one_hot_s;
  logic             accept_s;
  logic [RUN_W-1:0] run_inc_s;

  assign one_hot_s = is_one_hot3({a_eq_b, a_grt_b, a_less_b});
  assign accept_s  = flag_valid & one_hot_s;
  assign run_inc_s = run_q + RUN_ONE;

  // Next state: equal samples sit in the hysteresis band and cancel any pending run.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    case (state_q)
      ST_LOW: begin
        if (accept_s && a_grt_b) begin
          if (RUN_ONE == RUN_LAST) begin
            state_d = ST_HIGH;
            run_d   = RUN_ZERO;
          end else begin
            state_d = ST_RISING;
            run_d   = RUN_ONE;
          end
        end else if (accept_s) begin
          state_d = ST_LOW;
          run_d   = RUN_ZERO;
        end else begin
          state_d = state_q;
          run_d   = run_q;
        end
      end
      ST_RISING: begin
        if (accept_s && a_grt_b) begin
          if (run_inc_s == RUN_LAST) begin
            state_d = ST_HIGH;
            run_d   = RUN_ZERO;
          end else begin
            state_d = ST_RISING;
            run_d   = run_inc_s;
          end
        end else if (accept_s) begin
          state_d = ST_LOW;
          run_d   = RUN_ZERO;
        end else begin
          state_d = state_q;
          run_d   = run_q;
        end
      end
      ST_HIGH: begin
        if (accept_s && a_less_b) begin
          if (RUN_ONE == RUN_LAST) begin
            state_d = ST_LOW;
            run_d   = RUN_ZERO;
          end else begin
            state_d = ST_FALLING;
            run_d   = RUN_ONE;
          end
        end else if (accept_s) begin
          state_d = ST_HIGH;
          run_d   = RUN_ZERO;
        end else begin
          state_d = state_q;
          run_d   = run_q;
        end
      end
      ST_FALLING: begin
        if (accept_s && a_less_b) begin
          if (run_inc_s == RUN_LAST) begin
            state_d = ST_LOW;
            run_d   = RUN_ZERO;
          end else begin
            state_d = ST_FALLING;
            run_d   = run_inc_s;
          end
        end else if (accept_s) begin
          state_d = ST_HIGH;
          run_d   = RUN_ZERO;
        end else begin
          state_d = state_q;
          run_d   = run_q;
        end
      end
      default: begin
        state_d = ST_LOW;
        run_d   = RUN_ZERO;
      end
    endcase
  end

  // Registered outputs and counters derived from the transition being taken this edge.
  always_comb begin
    above_d = (state_d == ST_HIGH) || (state_d == ST_FALLING);
    rise_d  = (state_d == ST_HIGH) && ((state_q == ST_LOW) || (state_q == ST_RISING));
    fall_d  = (state_d == ST_LOW) && ((state_q == ST_HIGH) || (state_q == ST_FALLING));

    if (clear) begin
      eq_cnt_d = {CNT_W{1'b0}};
    end else if (accept_s && a_eq_b && (eq_cnt_q != CNT_MAX)) begin
      eq_cnt_d = eq_cnt_q + CNT_ONE;
    end else begin
      eq_cnt_d = eq_cnt_q;
    end

    if (clear) begin
      cross_d = {CNT_W{1'b0}};
    end else if ((rise_d || fall_d) && (cross_q != CNT_MAX)) begin
      cross_d = cross_q + CNT_ONE;
    end else begin
      cross_d = cross_q;
    end

    if (clear) begin
      err_d = 1'b0;
    end else if (flag_valid && !one_hot_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_LOW;
      run_q    <= RUN_ZERO;
      above_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      err_q    <= 1'b0;
      eq_cnt_q <= {CNT_W{1'b0}};
      cross_q  <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      above_q  <= above_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      err_q    <= err_d;
      eq_cnt_q <= eq_cnt_d;
      cross_q  <= cross_d;
    end
  end

  assign above       = above_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign flag_err    = err_q;
  assign eq_count    = eq_cnt_q;
  assign cross_count = cross_q;

endmodule
